// File: rtl/ifetch_if.sv
// Instruction-fetch read bus (Wishbone-style classic read cycle).
//   cyc/stb : transfer active, both driven high together by the master
//   adr     : 32-bit byte read address from the master
//   dat     : 32-bit read data returned by the memory
//   ack     : read data valid; ends the transfer in that cycle
interface ifetch_if;
  logic        cyc;
  logic        stb;
  logic [31:0] adr;
  logic [31:0] dat;
  logic        ack;

  modport master (output cyc, output stb, output adr, input dat, input ack);
  modport slave  (input cyc, input stb, input adr, output dat, output ack);
endinterface

// File: rtl/ifetch.sv
// Instruction fetch front end for the bexkat1 pipeline.
// Reads 32-bit words over the fetch bus and assembles them into a 64-bit instruction
// register. A first word with bit 0 set is followed by a 32-bit immediate word.
// Ports:
//   clk_i, rst_i  clock; asynchronous active-high reset
//   pc_set_i/pc_i redirect request and target from writeback (may be held several cycles)
//   stall_i       downstream stall; outputs hold while high
//   bus           fetch bus master (cyc/stb/adr out, dat/ack in)
//   ir_o          {immediate or 0, first word}
//   pc_o          address following the instruction in ir_o
//   valid_o       ir_o/pc_o hold a real instruction
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         pc_set_i,
  input  logic [31:0]  pc_i,
  input  logic         stall_i,
  ifetch_if.master     bus,
  output logic [63:0]  ir_o,
  output logic [31:0]  pc_o,
  output logic         valid_o
);

  typedef enum logic [2:0] {StStart, StW0, StW1, StDrain, StHold} state_e;

  state_e      state_q;
  logic [31:0] fetch_pc_q;
  logic [31:0] lo_q;
  logic [31:0] drain_adr_q;
  logic [63:0] hold_ir_q;
  logic        hold_long_q;

  logic        bus_active;
  logic [31:0] bus_adr;
  logic        done;
  logic        done_long;
  logic [63:0] done_ir;
  logic [31:0] done_next_pc;
  logic [31:0] hold_next_pc;

  // Bus outputs depend on state only, so an async reset drops cyc immediately.
  assign bus_active = (state_q == StW0) || (state_q == StW1) || (state_q == StDrain);

  always_comb begin
    bus_adr = 32'h0;
    case (state_q)
      StW0:    bus_adr = fetch_pc_q;
      StW1:    bus_adr = fetch_pc_q + 32'd4;
      StDrain: bus_adr = drain_adr_q;
      default: bus_adr = 32'h0;
    endcase
  end

  assign bus.cyc = bus_active;
  assign bus.stb = bus_active;
  assign bus.adr = bus_adr;

  // An instruction completes on the ack of its last word.
  always_comb begin
    done      = 1'b0;
    done_long = 1'b0;
    done_ir   = 64'h0;
    if (bus.ack) begin
      if (state_q == StW0 && !bus.dat[0]) begin
        done    = 1'b1;
        done_ir = {32'h0, bus.dat};
      end else if (state_q == StW1) begin
        done      = 1'b1;
        done_long = 1'b1;
        done_ir   = {bus.dat, lo_q};
      end
    end
  end

  assign done_next_pc = fetch_pc_q + (done_long ? 32'd8 : 32'd4);
  assign hold_next_pc = fetch_pc_q + (hold_long_q ? 32'd8 : 32'd4);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StStart;
      fetch_pc_q  <= RESET_PC;
      lo_q        <= 32'h0;
      drain_adr_q <= 32'h0;
      hold_ir_q   <= 64'h0;
      hold_long_q <= 1'b0;
      ir_o        <= 64'h0;
      pc_o        <= 32'h0;
      valid_o     <= 1'b0;
    end else if (pc_set_i) begin
      // Redirect wins over stall and completion; partial or buffered work is dropped.
      fetch_pc_q <= pc_i;
      valid_o    <= 1'b0;
      ir_o       <= 64'h0;
      if (bus_active && !bus.ack) begin
        state_q     <= StDrain;
        drain_adr_q <= bus_adr;
      end else begin
        state_q <= StStart;
      end
    end else begin
      // Bubble unless something below loads a real instruction.
      if (!stall_i) begin
        valid_o <= 1'b0;
        ir_o    <= 64'h0;
      end

      case (state_q)
        StStart: state_q <= StW0;
        StW0: begin
          if (bus.ack) begin
            lo_q <= bus.dat;
            if (bus.dat[0]) state_q <= StW1;
          end
        end
        StW1: ;
        StDrain: begin
          if (bus.ack) state_q <= StW0;
        end
        StHold: begin
          if (!stall_i) begin
            ir_o       <= hold_ir_q;
            pc_o       <= hold_next_pc;
            valid_o    <= 1'b1;
            fetch_pc_q <= hold_next_pc;
            state_q    <= StW0;
          end
        end
        default: state_q <= StStart;
      endcase

      if (done) begin
        if (!stall_i) begin
          ir_o       <= done_ir;
          pc_o       <= done_next_pc;
          valid_o    <= 1'b1;
          fetch_pc_q <= done_next_pc;
          state_q    <= StW0;
        end else begin
          // fetch_pc stays at the instruction address until the buffer is released.
          hold_ir_q   <= done_ir;
          hold_long_q <= done_long;
          state_q     <= StHold;
        end
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;
  localparam logic [31:0] RESET_PC = 32'h100;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        pc_set_i = 1'b0;
  logic [31:0] pc_i = 32'h0;
  logic        stall_i = 1'b0;
  logic [63:0] ir_o;
  logic [31:0] pc_o;
  logic        valid_o;

  int n_cmp = 0;
  int n_bad = 0;
  int ws = 0;     // wait states before ack
  int wcnt = 0;
  int acks8 = 0;

  ifetch_if bus ();

  ifetch #(.RESET_PC(RESET_PC)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .pc_set_i (pc_set_i),
    .pc_i     (pc_i),
    .stall_i  (stall_i),
    .bus      (bus),
    .ir_o     (ir_o),
    .pc_o     (pc_o),
    .valid_o  (valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h1000_0001;
      32'h0000_0004: return 32'hDEAD_BEEF;
      32'h0000_0008: return 32'h5000_0000;
      32'h0000_000C: return 32'h6000_0001;
      32'h0000_0100: return 32'h2000_0000;
      32'h0000_0104: return 32'h3000_0000;
      32'h0000_0108: return 32'h4000_0000;
      32'h0000_0400: return 32'h7000_0000;
      32'h0000_0404: return 32'h1111_0001;
      32'h0000_0408: return 32'h2222_2222;
      32'h0000_0500: return 32'h3333_0000;
      32'h0000_0504: return 32'h4444_0000;
      32'h0000_0600: return 32'h5555_0000;
      32'hFFFF_FFFC: return 32'h6666_0000;
      default:       return 32'h0;
    endcase
  endfunction

  assign bus.dat = mem_rd(bus.adr);
  assign bus.ack = bus.cyc && (wcnt >= ws);

  always @(posedge clk) begin
    if (bus.cyc && !bus.ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (bus.ack && bus.adr == 32'h8) acks8 <= acks8 + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: the instruction at address p and the address that follows it.
  function automatic void ref_instr(input logic [31:0] p, output logic [63:0] ir,
                                    output logic [31:0] np);
    logic [31:0] w0;
    w0 = mem_rd(p);
    if (w0[0]) begin
      ir = {mem_rd(p + 32'd4), w0};
      np = p + 32'd8;
    end else begin
      ir = {32'h0, w0};
      np = p + 32'd4;
    end
  endfunction

  // Edge-level facts the model needs: was a redirect or a free (unstalled) edge seen.
  logic        redir_seen = 1'b0;
  logic [31:0] redir_pc = 32'h0;
  logic        free_edge = 1'b0;

  always @(posedge clk) begin
    redir_seen <= pc_set_i && !rst_i;
    redir_pc   <= pc_i;
    free_edge  <= !rst_i && !pc_set_i && !stall_i;
  end

  logic [31:0] model_pc = RESET_PC;
  logic [63:0] exp_ir = 64'h0;
  logic [31:0] exp_pc = 32'h0;
  logic        have_exp = 1'b0;

  always @(negedge clk) begin
    check("stb_eq_cyc", 64'(bus.stb), 64'(bus.cyc));
    if (rst_i) begin
      model_pc = RESET_PC;
      have_exp = 1'b0;
    end else begin
      if (redir_seen) model_pc = redir_pc;
      if (!valid_o) begin
        check("bubble_ir_zero", ir_o, 64'h0);
      end else if (free_edge) begin
        ref_instr(model_pc, exp_ir, exp_pc);
        model_pc = exp_pc;
        have_exp = 1'b1;
        check("model_ir", ir_o, exp_ir);
        check("model_pc", 64'(pc_o), 64'(exp_pc));
      end else begin
        check("held_has_instr", 64'(have_exp), 64'd1);
        check("held_ir", ir_o, exp_ir);
        check("held_pc", 64'(pc_o), 64'(exp_pc));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic out_chk(input string name, input logic v, input logic [63:0] ir,
                         input logic [31:0] pc);
    check({name, "_valid"}, 64'(valid_o), 64'(v));
    check({name, "_ir"}, ir_o, ir);
    check({name, "_pc"}, 64'(pc_o), 64'(pc));
  endtask

  task automatic bus_chk(input string name, input logic cyc, input logic [31:0] adr);
    check({name, "_cyc"}, 64'(bus.cyc), 64'(cyc));
    if (cyc) check({name, "_adr"}, 64'(bus.adr), 64'(adr));
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!valid_o && n < 12) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, 64'(valid_o), 64'd1);
  endtask

  initial begin
    // Reset state
    tick();
    out_chk("reset", 1'b0, 64'h0, 32'h0);
    bus_chk("reset", 1'b0, 32'h0);
    rst_i = 1'b0;

    // Short-form stream from RESET_PC, zero wait states
    tick();
    bus_chk("short_a0", 1'b1, 32'h100);
    tick();
    out_chk("short_i0", 1'b1, 64'h0000_0000_2000_0000, 32'h104);
    bus_chk("short_a1", 1'b1, 32'h104);
    tick();
    out_chk("short_i1", 1'b1, 64'h0000_0000_3000_0000, 32'h108);

    // Redirect to 0 for the long form
    pc_set_i = 1'b1;
    pc_i = 32'h0;
    tick();
    out_chk("redir0", 1'b0, 64'h0, 32'h108);
    bus_chk("redir0", 1'b0, 32'h0);
    pc_set_i = 1'b0;
    tick();
    bus_chk("long_a0", 1'b1, 32'h0);
    tick();
    bus_chk("long_a1", 1'b1, 32'h4);
    check("long_bubble", 64'(valid_o), 64'd0);
    tick();
    out_chk("long", 1'b1, 64'hDEAD_BEEF_1000_0001, 32'h8);
    bus_chk("long_next", 1'b1, 32'h8);

    // Stall for three edges while the word at 0x8 completes
    stall_i = 1'b1;
    tick();
    out_chk("stall1", 1'b1, 64'hDEAD_BEEF_1000_0001, 32'h8);
    bus_chk("stall1", 1'b0, 32'h0);
    tick();
    out_chk("stall2", 1'b1, 64'hDEAD_BEEF_1000_0001, 32'h8);
    bus_chk("stall2", 1'b0, 32'h0);
    tick();
    out_chk("stall3", 1'b1, 64'hDEAD_BEEF_1000_0001, 32'h8);
    stall_i = 1'b0;
    tick();
    out_chk("unstall", 1'b1, 64'h0000_0000_5000_0000, 32'hC);
    bus_chk("unstall", 1'b1, 32'hC);
    check("no_refetch_8", 64'(acks8), 64'd1);

    // Redirect with an outstanding transfer (3 wait states)
    ws = 3;
    tick();
    pc_set_i = 1'b1;
    pc_i = 32'h400;
    tick();
    bus_chk("drain1", 1'b1, 32'hC);
    out_chk("drain1", 1'b0, 64'h0, 32'hC);
    tick();
    pc_set_i = 1'b0;
    bus_chk("drain2", 1'b1, 32'hC);
    tick();
    bus_chk("after_drain", 1'b1, 32'h400);
    check("after_drain_valid", 64'(valid_o), 64'd0);
    wait_valid("ws3");
    out_chk("ws3", 1'b1, 64'h0000_0000_7000_0000, 32'h404);

    // Redirect during W1 of a long instruction
    ws = 0;
    tick();
    bus_chk("w1", 1'b1, 32'h408);
    pc_set_i = 1'b1;
    pc_i = 32'h500;
    tick();
    out_chk("redir_w1", 1'b0, 64'h0, 32'h404);
    bus_chk("redir_w1", 1'b0, 32'h0);
    pc_set_i = 1'b0;
    tick();
    bus_chk("w1_resume", 1'b1, 32'h500);
    tick();
    out_chk("w1_resume", 1'b1, 64'h0000_0000_3333_0000, 32'h504);

    // Redirect while stalled with a buffered instruction
    stall_i = 1'b1;
    tick();
    out_chk("stall_buf", 1'b1, 64'h0000_0000_3333_0000, 32'h504);
    pc_set_i = 1'b1;
    pc_i = 32'h600;
    tick();
    out_chk("redir_stall", 1'b0, 64'h0, 32'h504);
    bus_chk("redir_stall", 1'b0, 32'h0);
    pc_set_i = 1'b0;
    stall_i = 1'b0;
    tick();
    bus_chk("stall_resume", 1'b1, 32'h600);
    tick();
    out_chk("stall_resume", 1'b1, 64'h0000_0000_5555_0000, 32'h604);

    // Wrap-around at the top of the address space
    pc_set_i = 1'b1;
    pc_i = 32'hFFFF_FFFC;
    tick();
    pc_set_i = 1'b0;
    tick();
    bus_chk("wrap_a", 1'b1, 32'hFFFF_FFFC);
    tick();
    out_chk("wrap", 1'b1, 64'h0000_0000_6666_0000, 32'h0);
    bus_chk("wrap_next", 1'b1, 32'h0);

    // Reset pulsed mid-W1
    tick();
    bus_chk("pre_rst_w1", 1'b1, 32'h4);
    ws = 2;
    #1;
    rst_i = 1'b1;
    #1;
    bus_chk("rst_async", 1'b0, 32'h0);
    out_chk("rst_async", 1'b0, 64'h0, 32'h0);
    tick();
    rst_i = 1'b0;
    ws = 0;
    tick();
    bus_chk("post_rst", 1'b1, RESET_PC);
    tick();
    out_chk("post_rst", 1'b1, 64'h0000_0000_2000_0000, 32'h104);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
- Front end of the bexkat1 pipeline, fetching 32-bit words from instruction memory over a classic Wishbone-style read bus.
- Assembles each instruction into a 64-bit instruction register: the short form is one word; when bit 0 of the first word is set, a second word (the immediate) follows.
- Accepts PC redirects from the writeback stage (pc_set_i/pc_i) and honours pipeline stall from downstream.

Parameters:
RESET_PC, 32'h0, byte address of the first instruction fetched after reset.

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, asynchronous, active-high
pc_set_i  input  1  redirect request from writeback; may stay high for several cycles
pc_i  input  32  redirect target, valid while pc_set_i high
stall_i  input  1  downstream stall; hold outputs
bus_cyc_o  output  1  bus cycle active
bus_stb_o  output  1  bus strobe (equals bus_cyc_o)
bus_adr_o  output  32  byte read address
bus_dat_i  input  32  read data
bus_ack_i  input  1  read data valid, terminates the transfer
ir_o  output  64  instruction: [31:0] first word, [63:32] immediate, or 0 for short form
pc_o  output  32  address following this instruction: instr addr +4 for short form, +8 for long form
valid_o  output  1  ir_o/pc_o hold a real instruction

Behaviour:
- Reset (async) values:
  - ir_o=0, pc_o=0, valid_o=0.
  - Internal fetch_pc=RESET_PC; state=START.
  - Bus outputs 0.
- Bus outputs are combinational from state:
  - cyc=stb=1 in W0, W1 and DRAIN.
  - adr=fetch_pc in W0 and fetch_pc+4 in W1.
  - All bus outputs 0 in START and HOLD.
- States and transitions:
  - START → W0 on the next clock.
  - W0, on ack: latch bus_dat_i as lo.
    - If bus_dat_i[0]=1 → W1.
    - Else the instruction is complete with ir={32'h0,lo}, len=4.
  - W1, on ack: the instruction is complete with ir={bus_dat_i,lo}, len=8.
  - Without ack, W0 and W1 hold state, keeping cyc/stb/adr stable.
- On completion:
  - If stall_i=0: ir_o←ir, pc_o←fetch_pc+len, valid_o←1, fetch_pc←fetch_pc+len, then → W0. There is no idle cycle between instructions.
  - If stall_i=1: the instruction is buffered internally and the state → HOLD. The bus stays idle while in HOLD.
- HOLD: when stall_i=0, load the buffered instruction to the outputs as above, then → W0.
- Output register rules:
  - While stall_i=1, ir_o/pc_o/valid_o hold their values.
  - When stall_i=0 and no instruction completes this cycle, the stage emits a bubble: valid_o←0, ir_o←0, pc_o unchanged.
- Redirect (pc_set_i=1 sampled at a clock edge) has priority over stall and over completion:
  - fetch_pc←pc_i, valid_o←0, ir_o←0.
  - Any partially assembled or buffered instruction is discarded.
  - If a bus transfer is outstanding and unacked this cycle → DRAIN. Otherwise → START.
  - While pc_set_i remains high, the state stays in START or DRAIN and fetch_pc keeps being reloaded from pc_i.
  - Fetching at the new PC starts the cycle after pc_set_i drops: START → W0.
- DRAIN:
  - Holds cyc/stb asserted with the old address until ack; the ack data is discarded.
  - Then → START, or → W0 directly if pc_set_i=0.
- Wrap-around: fetch_pc arithmetic is mod 2^32 (0xFFFFFFFC+4=0).
- An ack in any state other than W0, W1 or DRAIN is ignored.
- Reset asserted mid-transfer aborts immediately: cyc drops asynchronously with state=START.

Test Plan:
- Short-form stream: RESET_PC=0x100, memory 0x100=0x20000000, 0x104=0x30000000, ack in the same cycle → bus adr 0x100 then 0x104 back-to-back; ir_o=0x0000000020000000 with pc_o=0x104, then ir_o=0x30000000 with pc_o=0x108, valid_o=1 each.
- Long form: word 0x10000001 at 0x0, immediate 0xDEADBEEF at 0x4 → single output ir_o=0xDEADBEEF10000001, pc_o=0x8, next fetch adr 0x8.
- Stall: assert stall_i for 3 cycles while the fetch completes → outputs frozen, bus idle in HOLD; on release the buffered instruction appears on the next edge with valid_o=1 and no re-fetch of its address.
- Redirect with outstanding transfer: 3-wait-state memory, pc_set_i=1 for 2 cycles with pc_i=0x400 mid-W0 → DRAIN until ack, valid_o=0, ir_o=0; next adr is 0x400 after pc_set_i drops; the old data never appears on ir_o.
- Redirect during stall and during W1: pc_set_i while stall_i=1 or after the first word of a long instruction → partial instruction discarded; fetch resumes at pc_i.
- Wrap and reset: fetch_pc=0xFFFFFFFC short instruction → pc_o=0x0, next adr 0x0; rst_i pulsed mid-W1 → bus_cyc_o=0 immediately, first post-reset adr = RESET_PC.
